argmax_ctrl: RTL and testbench

Sequencer and arg-max engine for the classifier output stage. On `start`, it walks the final fully-connected layer's score buffer two channels per cycle. It tracks the running maximum and its channel index, then presents the winning class on a valid/ready output. It replaces free-running index-driven max tracking with an explicit start/busy/done protocol and deterministic tie handling.

---
 rtl/argmax_pkg.sv | 16 +
 rtl/argmax_pair_cmp.sv | 38 +++
 rtl/argmax_ctrl.sv | 126 ++++++++++++
 tb/tb_argmax_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// Shared constants and helpers for the classifier arg-max sequencer.
package argmax_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam int CLASS_W = 5;

   // Number of two-channel reads needed to cover every class score.
   function automatic int pairCount(input int channels);
      return (channels + 1) / 2;
   endfunction

endpackage

// File: rtl/argmax_pair_cmp.sv
// Folds one score pair into a running maximum; strict-greater updates, so ties keep the lower index.
module argmax_pair_cmp
   import argmax_pkg::*;
#(
   parameter int SW = 17
) (
   input  logic signed [SW-1:0]      curMax_i,
   input  logic        [CLASS_W-1:0] curIdx_i,
   input  logic signed [SW-1:0]      scoreA_i,
   input  logic signed [SW-1:0]      scoreB_i,
   input  logic        [CLASS_W-1:0] baseIdx_i,
   input  logic                      bValid_i,
   output logic signed [SW-1:0]      newMax_o,
   output logic        [CLASS_W-1:0] newIdx_o
);

   logic signed [SW-1:0]      midMax;
   logic        [CLASS_W-1:0] midIdx;

   // Channel 2k is judged first so that channel 2k+1 only wins if it beats both.
   always_comb begin
      midMax   = curMax_i;
      midIdx   = curIdx_i;
      newMax_o = curMax_i;
      newIdx_o = curIdx_i;
      if (scoreA_i > curMax_i) begin
         midMax = scoreA_i;
         midIdx = baseIdx_i;
      end
      newMax_o = midMax;
      newIdx_o = midIdx;
      if (bValid_i && (scoreB_i > midMax)) begin
         newMax_o = scoreB_i;
         newIdx_o = baseIdx_i + CLASS_W'(1);
      end
   end

endmodule

// File: rtl/argmax_ctrl.sv
// Start/busy/done arg-max engine over the final layer's score buffer, two channels per read.
// Optional bias addition is enabled by defining ARGMAX_BIAS_EN.
module argmax_ctrl
   import argmax_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int OUTPUT_CHANNEL = 10,
   parameter int ADDR_W         = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         busy,
   output logic                         rd_en,
   output logic        [ADDR_W-1:0]     rd_addr,
   input  logic signed [DATA_WIDTH-1:0] rd_data_a,
   input  logic signed [DATA_WIDTH-1:0] rd_data_b,
`ifdef ARGMAX_BIAS_EN
   input  logic signed [DATA_WIDTH-1:0] bias_a,
   input  logic signed [DATA_WIDTH-1:0] bias_b,
`endif
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic        [CLASS_W-1:0]    class_idx,
   output logic signed [DATA_WIDTH:0]   max_val
);

   localparam int                SW        = DATA_WIDTH + 1;
   localparam int                P         = pairCount(OUTPUT_CHANNEL);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(P - 1);
   localparam bit                ODD_COUNT = (OUTPUT_CHANNEL % 2) == 1;

   logic [1:0]               state_q, state_d;
   logic [ADDR_W-1:0]        pairCnt_q, pairCnt_d;
   logic                     cmpValid_q;
   logic [ADDR_W-1:0]        cmpAddr_q;
   logic signed [SW-1:0]     maxVal_q;
   logic [CLASS_W-1:0]       maxIdx_q;

   logic signed [SW-1:0]     scoreA, scoreB, curMax, newMax;
   logic [CLASS_W-1:0]       curIdx, baseIdx, newIdx;
   logic                     firstPair, bValid;

   always_comb begin
      state_d   = state_q;
      pairCnt_d = pairCnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               pairCnt_d = '0;
               state_d   = READ;
            end
         end
         READ: begin
            if (pairCnt_q == LAST_ADDR) begin
               state_d = DRAIN;
            end else begin
               pairCnt_d = pairCnt_q + 1'b1;
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef ARGMAX_BIAS_EN
   assign scoreA = {rd_data_a[DATA_WIDTH-1], rd_data_a} + {bias_a[DATA_WIDTH-1], bias_a};
   assign scoreB = {rd_data_b[DATA_WIDTH-1], rd_data_b} + {bias_b[DATA_WIDTH-1], bias_b};
`else
   assign scoreA = {rd_data_a[DATA_WIDTH-1], rd_data_a};
   assign scoreB = {rd_data_b[DATA_WIDTH-1], rd_data_b};
`endif

   // Pair 0 seeds the running max with channel 0, so its self-compare never replaces it.
   assign firstPair = (cmpAddr_q == '0);
   assign curMax    = firstPair ? scoreA : maxVal_q;
   assign curIdx    = firstPair ? '0 : maxIdx_q;
   assign baseIdx   = CLASS_W'({cmpAddr_q, 1'b0});
   assign bValid    = !(ODD_COUNT && (cmpAddr_q == LAST_ADDR));

   argmax_pair_cmp #(
      .SW (SW)
   ) u_pairCmp (
      .curMax_i  (curMax),
      .curIdx_i  (curIdx),
      .scoreA_i  (scoreA),
      .scoreB_i  (scoreB),
      .baseIdx_i (baseIdx),
      .bValid_i  (bValid),
      .newMax_o  (newMax),
      .newIdx_o  (newIdx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pairCnt_q  <= '0;
         cmpValid_q <= 1'b0;
         cmpAddr_q  <= '0;
         maxVal_q   <= '0;
         maxIdx_q   <= '0;
      end else begin
         state_q    <= state_d;
         pairCnt_q  <= pairCnt_d;
         cmpValid_q <= (state_q == READ);
         cmpAddr_q  <= pairCnt_q;
         if (cmpValid_q) begin
            maxVal_q <= newMax;
            maxIdx_q <= newIdx;
         end
      end
   end

   assign busy      = (state_q != IDLE);
   assign rd_en     = (state_q == READ);
   assign rd_addr   = pairCnt_q;
   assign out_valid = (state_q == DONE);
   assign class_idx = maxIdx_q;
   assign max_val   = maxVal_q;

endmodule

// File: tb/tb_argmax_ctrl.sv
// Self-checking bench for argmax_ctrl: fixed vectors, random searches against a plain arg-max model,
// and hand-written back-pressure, reset-abort and odd-channel-count sequences.
module tb_argmax_ctrl;

   localparam int DW    = 16;
   localparam int NA    = 10;
   localparam int PA    = 5;
   localparam int NB    = 5;
   localparam int PB    = 3;
   localparam int LIMIT = 40;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                 startA, busyA, rdEnA, outValidA, outReadyA;
   logic [3:0]           rdAddrA;
   logic signed [DW-1:0] rdDataAa, rdDataAb;
   logic [4:0]           classIdxA;
   logic signed [DW:0]   maxValA;

   logic                 startB, busyB, rdEnB, outValidB, outReadyB;
   logic [1:0]           rdAddrB;
   logic signed [DW-1:0] rdDataBa, rdDataBb;
   logic [4:0]           classIdxB;
   logic signed [DW:0]   maxValB;

   logic signed [DW-1:0] memA [NA];
   logic signed [DW-1:0] memB [NB+1];
   int                   readsA = 0;
   int                   readsB = 0;

`ifdef ARGMAX_BIAS_EN
   logic signed [DW-1:0] biasMemA [NA];
   logic signed [DW-1:0] biasAa, biasAb;
`endif

   int checks = 0;
   int errors = 0;

   argmax_ctrl #(.DATA_WIDTH(DW), .OUTPUT_CHANNEL(NA), .ADDR_W(4)) dutA (
      .clk       (clk),
      .rst       (rst),
      .start     (startA),
      .busy      (busyA),
      .rd_en     (rdEnA),
      .rd_addr   (rdAddrA),
      .rd_data_a (rdDataAa),
      .rd_data_b (rdDataAb),
`ifdef ARGMAX_BIAS_EN
      .bias_a    (biasAa),
      .bias_b    (biasAb),
`endif
      .out_valid (outValidA),
      .out_ready (outReadyA),
      .class_idx (classIdxA),
      .max_val   (maxValA)
   );

   argmax_ctrl #(.DATA_WIDTH(DW), .OUTPUT_CHANNEL(NB), .ADDR_W(2)) dutB (
      .clk       (clk),
      .rst       (rst),
      .start     (startB),
      .busy      (busyB),
      .rd_en     (rdEnB),
      .rd_addr   (rdAddrB),
      .rd_data_a (rdDataBa),
      .rd_data_b (rdDataBb),
`ifdef ARGMAX_BIAS_EN
      .bias_a    ('0),
      .bias_b    ('0),
`endif
      .out_valid (outValidB),
      .out_ready (outReadyB),
      .class_idx (classIdxB),
      .max_val   (maxValB)
   );

   // Score buffers: one-cycle read latency, garbage on the data bus whenever no read was issued.
   always @(posedge clk) begin
      if (rdEnA) begin
         rdDataAa <= memA[2*int'(rdAddrA)];
         rdDataAb <= memA[2*int'(rdAddrA)+1];
`ifdef ARGMAX_BIAS_EN
         biasAa   <= biasMemA[2*int'(rdAddrA)];
         biasAb   <= biasMemA[2*int'(rdAddrA)+1];
`endif
         readsA   <= readsA + 1;
      end else begin
         rdDataAa <= DW'($urandom);
         rdDataAb <= DW'($urandom);
`ifdef ARGMAX_BIAS_EN
         biasAa   <= DW'($urandom);
         biasAb   <= DW'($urandom);
`endif
      end
      if (rdEnB) begin
         rdDataBa <= memB[2*int'(rdAddrB)];
         rdDataBb <= memB[2*int'(rdAddrB)+1];
         readsB   <= readsB + 1;
      end else begin
         rdDataBa <= DW'($urandom);
         rdDataBb <= DW'($urandom);
      end
   end

   typedef struct {
      int sc [NA];
      int expIdx;
      int expVal;
   } vec_t;

   vec_t vecs [5];

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Arg-max as stated: first index holding the largest value.
   function automatic void refModel(input int s [NA], input int n, output int idx, output int val);
      idx = 0;
      val = s[0];
      for (int i = 1; i < n; i++) begin
         if (s[i] > val) begin
            val = s[i];
            idx = i;
         end
      end
   endfunction

   task automatic loadA(input int sc [NA]);
      for (int i = 0; i < NA; i++) begin
         memA[i] = DW'(sc[i]);
`ifdef ARGMAX_BIAS_EN
         biasMemA[i] = '0;
`endif
      end
   endtask

   // Runs one search on dutA with out_ready high; lat counts edges from the start edge to out_valid.
   task automatic applyStimulus(output int idx, output int val, output int lat, output int reads);
      int r0;
      r0 = readsA;
      startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      lat = 0;
      while (!outValidA && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
      if (!outValidA) begin
         lat = -1;
      end
      idx   = classIdxA;
      val   = maxValA;
      reads = readsA - r0;
      @(negedge clk);
   endtask

   initial begin
      int idx, val, lat, reads, expIdx, expVal, r0;
      int sc [NA];
      int eff [NA];
      logic signed [DW-1:0] r;
      int holdIdx, holdVal, sawValid;

      vecs[0].sc = '{3, -1, 7, 7, 2, 0, -5, 6, 1, 4};
      vecs[0].expIdx = 2;  vecs[0].expVal = 7;
      vecs[1].sc = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
      vecs[1].expIdx = 0;  vecs[1].expVal = -32768;
      vecs[2].sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32767};
      vecs[2].expIdx = 9;  vecs[2].expVal = 32767;
      vecs[3].sc = '{-7, -3, -3, -9, -8, -8, -4, -5, -6, -3};
      vecs[3].expIdx = 1;  vecs[3].expVal = -3;
      vecs[4].sc = '{-2, 40, 41, 0, 5, 41, 12, 100, 100, -100};
      vecs[4].expIdx = 7;  vecs[4].expVal = 100;

      rst = 1'b1;
      startA = 1'b0;  outReadyA = 1'b1;
      startB = 1'b0;  outReadyB = 1'b1;
      for (int i = 0; i < NB + 1; i++) memB[i] = '0;
      loadA(vecs[0].sc);
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_busy", busyA, 0);
      checkOutput("reset_rd_en", rdEnA, 0);
      checkOutput("reset_out_valid", outValidA, 0);
      checkOutput("reset_rd_addr", rdAddrA, 0);
      checkOutput("reset_class_idx", classIdxA, 0);
      checkOutput("reset_max_val", maxValA, 0);
      rst = 1'b0;
      @(negedge clk);

      // Fixed vectors
      for (int v = 0; v < 5; v++) begin
         loadA(vecs[v].sc);
         applyStimulus(idx, val, lat, reads);
         checkOutput($sformatf("vec%0d_class_idx", v), idx, vecs[v].expIdx);
         checkOutput($sformatf("vec%0d_max_val", v), val, vecs[v].expVal);
         checkOutput($sformatf("vec%0d_latency", v), lat, PA + 1);
         checkOutput($sformatf("vec%0d_reads", v), reads, PA);
         checkOutput($sformatf("vec%0d_busy_after", v), busyA, 0);
      end

      // Random searches against the model
      for (int t = 0; t < 25; t++) begin
         int mode;
         mode = $urandom_range(0, 2);
         for (int i = 0; i < NA; i++) begin
            r = DW'($urandom);
            if (mode == 0) sc[i] = r;
            else if (mode == 1) sc[i] = $urandom_range(0, 6) - 3;
            else sc[i] = ($urandom_range(0, 2) == 0) ? -32768 : (($urandom_range(0, 1) == 0) ? 32767 : 0);
         end
         loadA(sc);
         for (int i = 0; i < NA; i++) eff[i] = sc[i];
`ifdef ARGMAX_BIAS_EN
         for (int i = 0; i < NA; i++) begin
            r = DW'($urandom);
            biasMemA[i] = (mode == 0) ? r : DW'($urandom_range(0, 4) - 2);
            eff[i] = sc[i] + int'(biasMemA[i]);
         end
`endif
         refModel(eff, NA, expIdx, expVal);
         applyStimulus(idx, val, lat, reads);
         checkOutput($sformatf("rand%0d_class_idx", t), idx, expIdx);
         checkOutput($sformatf("rand%0d_max_val", t), val, expVal);
         checkOutput($sformatf("rand%0d_latency", t), lat, PA + 1);
      end

      // Back-pressure in DONE with extra start pulses
      loadA(vecs[0].sc);
      outReadyA = 1'b0;
      startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      lat = 0;
      while (!outValidA && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("bp_out_valid_rise", outValidA, 1);
      checkOutput("bp_class_idx", classIdxA, 2);
      checkOutput("bp_max_val", maxValA, 7);
      holdIdx = classIdxA;
      holdVal = maxValA;
      for (int k = 0; k < 4; k++) begin
         startA = (k % 2 == 0);
         @(negedge clk);
         checkOutput($sformatf("bp_hold%0d_valid", k), outValidA, 1);
         checkOutput($sformatf("bp_hold%0d_busy", k), busyA, 1);
         checkOutput($sformatf("bp_hold%0d_class_idx", k), classIdxA, holdIdx);
         checkOutput($sformatf("bp_hold%0d_max_val", k), maxValA, holdVal);
      end
      startA = 1'b0;
      outReadyA = 1'b1;
      @(negedge clk);
      checkOutput("bp_busy_after", busyA, 0);
      sawValid = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (outValidA || busyA) sawValid++;
      end
      checkOutput("bp_single_result", sawValid, 0);

      // Reset in the middle of a search
      loadA(vecs[2].sc);
      startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", busyA, 0);
      checkOutput("abort_rd_en", rdEnA, 0);
      checkOutput("abort_out_valid", outValidA, 0);
      checkOutput("abort_rd_addr", rdAddrA, 0);
      checkOutput("abort_class_idx", classIdxA, 0);
      checkOutput("abort_max_val", maxValA, 0);
      rst = 1'b0;
      @(negedge clk);
      loadA(vecs[3].sc);
      applyStimulus(idx, val, lat, reads);
      checkOutput("post_abort_class_idx", idx, 1);
      checkOutput("post_abort_max_val", val, -3);
      checkOutput("post_abort_latency", lat, PA + 1);

      // Odd channel count: the unused slot of the last pair must never win
      memB[0] = 2;  memB[1] = -5;  memB[2] = 9;
      memB[3] = 3;  memB[4] = 10;  memB[5] = 32767;
      r0 = readsB;
      startB = 1'b1;
      @(negedge clk);
      startB = 1'b0;
      lat = 0;
      while (!outValidB && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
      if (!outValidB) lat = -1;
      checkOutput("odd_class_idx", classIdxB, 4);
      checkOutput("odd_max_val", maxValB, 10);
      checkOutput("odd_latency", lat, PB + 1);
      checkOutput("odd_reads", readsB - r0, PB);
      @(negedge clk);
      checkOutput("odd_busy_after", busyB, 0);

`ifdef ARGMAX_BIAS_EN
      // Bias alone decides the winner when all scores are equal
      for (int i = 0; i < NA; i++) begin
         memA[i] = '0;
         biasMemA[i] = (i == 6) ? 16'sd5 : 16'sd0;
      end
      applyStimulus(idx, val, lat, reads);
      checkOutput("bias_class_idx", idx, 6);
      checkOutput("bias_max_val", val, 5);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
